// File: rtl/watch_set_controller.sv
// Watch time-set sequencer: walks hour/min/sec fields, turns up/down buttons into inc/dec pulses, drives blink.
// Build option: define SET_AUTO_REPEAT_EN to compile in hold-to-repeat; otherwise one pulse per press.
module watch_set_controller #(
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned REPEAT_CYCLES  = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
    parameter int unsigned BLINK_HALF     = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic       i_set,
    input  logic       i_up,
    input  logic       i_down,
    output logic       o_setting,
    output logic [1:0] o_field,
    output logic       o_inc,
    output logic       o_dec,
    output logic       o_blink
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BL_W = $clog2(BLINK_HALF + 1);

    // Zero-length periods are not a meaningful configuration.
    if (HOLD_CYCLES == 0 || REPEAT_CYCLES == 0 || TIMEOUT_CYCLES == 0 || BLINK_HALF == 0) begin : g_bad_cfg
        $error("watch_set_controller: cycle parameters must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] act_cnt_q, act_cnt_d;
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            up_q, dn_q;
    logic            setting_d, inc_d, dec_d, blink_d;
    logic [1:0]      field_d;

    logic single_up, single_dn, up_rise, dn_rise;
    logic in_set, activity, timed_out, pulse_ok, rpt_fire;

    // Both buttons high counts as released, so the survivor re-arms its edge.
    assign single_up = i_up & ~i_down;
    assign single_dn = i_down & ~i_up;
    assign up_rise   = single_up & ~up_q;
    assign dn_rise   = single_dn & ~dn_q;
    assign in_set    = (state_q != IDLE);
    assign activity  = i_set | i_up | i_down;
    assign timed_out = in_set && (act_cnt_q == TO_W'(TIMEOUT_CYCLES));
    assign pulse_ok  = i_enable & in_set & ~i_set;

`ifdef SET_AUTO_REPEAT_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;

    // hold_cnt runs from the press up to HOLD_CYCLES, then rep_cnt paces the repeats.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        rpt_fire   = 1'b0;
        if (!i_enable || !in_set || !(single_up || single_dn)) begin
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
        end else if (up_rise || dn_rise || (i_set && hold_cnt_q != '0)) begin
            hold_cnt_d = HOLD_W'(1);
            rep_cnt_d  = '0;
        end else if (hold_cnt_q != '0) begin
            if (hold_cnt_q != HOLD_W'(HOLD_CYCLES)) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else if (rep_cnt_q == '0 || rep_cnt_q == REP_W'(REPEAT_CYCLES)) begin
                rpt_fire  = 1'b1;
                rep_cnt_d = REP_W'(1);
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Field sequencing; enable loss and timeout override i_set.
    always_comb begin
        state_d = state_q;
        if (!i_enable || timed_out) begin
            state_d = IDLE;
        end else if (i_set) begin
            case (state_q)
                IDLE:     state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        setting_d   = (state_d != IDLE);
        field_d     = 2'(state_d);
        inc_d       = pulse_ok & single_up & (up_rise | rpt_fire);
        dec_d       = pulse_ok & single_dn & (dn_rise | rpt_fire);
        act_cnt_d   = act_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = o_blink;

        if (!i_enable || !in_set || activity) begin
            act_cnt_d = '0;
        end else if (act_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            act_cnt_d = act_cnt_q + TO_W'(1);
        end

        // Digits stay lit while adjusting and restart their phase on each field change.
        if (!i_enable || state_d == IDLE || state_d != state_q || i_up || i_down) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
            blink_d     = ~o_blink;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_setting   <= 1'b0;
            o_field     <= 2'b00;
            o_inc       <= 1'b0;
            o_dec       <= 1'b0;
            o_blink     <= 1'b1;
            act_cnt_q   <= '0;
            blink_cnt_q <= '0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
        end else begin
            o_setting   <= setting_d;
            o_field     <= field_d;
            o_inc       <= inc_d;
            o_dec       <= dec_d;
            o_blink     <= blink_d;
            act_cnt_q   <= act_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            up_q        <= i_enable & single_up;
            dn_q        <= i_enable & single_dn;
        end
    end

endmodule

// File: tb/tb_watch_set_controller.sv
// Scoreboard bench for watch_set_controller: stimulus queues expected pulses/field changes, a monitor checks them.
module tb_watch_set_controller;

    localparam int unsigned HOLD  = 8;
    localparam int unsigned REP   = 4;
    localparam int unsigned TMO   = 50;
    localparam int unsigned BLINK = 5;

    localparam int K_INC   = 0;
    localparam int K_DEC   = 1;
    localparam int K_FIELD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_enable = 1'b1;
    logic       i_set = 1'b0;
    logic       i_up = 1'b0;
    logic       i_down = 1'b0;
    logic       o_setting;
    logic [1:0] o_field;
    logic       o_inc;
    logic       o_dec;
    logic       o_blink;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // cyc = -1 means the event may arrive on any cycle.
    typedef struct {
        int         cyc;
        int         kind;
        logic [1:0] fld;
    } ev_t;

    ev_t        exp_q[$];
    logic [1:0] prev_field = 2'b00;

    watch_set_controller #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .TIMEOUT_CYCLES(TMO),
        .BLINK_HALF    (BLINK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_enable (i_enable),
        .i_set    (i_set),
        .i_up     (i_up),
        .i_down   (i_down),
        .o_setting(o_setting),
        .o_field  (o_field),
        .o_inc    (o_inc),
        .o_dec    (o_dec),
        .o_blink  (o_blink)
    );

    always #5 clk = ~clk;

    // At a negedge, cyc is the number of the rising edge that just registered the outputs.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int kind, input logic [1:0] fld);
        ev_t e;
        e.cyc  = c;
        e.kind = kind;
        e.fld  = fld;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [1:0] fld);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: kind %0d field %0d at cycle %0d, none required", kind, fld, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (e.cyc >= 0 && e.cyc != cyc) || (kind == K_FIELD && e.fld != fld)) begin
                failures++;
                $display("FAIL event: got kind %0d field %0d cycle %0d, required kind %0d field %0d cycle %0d",
                         kind, fld, cyc, e.kind, e.fld, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (o_inc) observe(K_INC, 2'b00);
        if (o_dec) observe(K_DEC, 2'b00);
        if (o_field != prev_field) observe(K_FIELD, o_field);
        prev_field = o_field;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; i_set is sampled on the next rising edge.
    task automatic set_pulse(input logic [1:0] fld);
        push(cyc + 1, K_FIELD, fld);
        i_set = 1'b1;
        step(1);
        i_set = 1'b0;
        chk("field_after_set", int'(o_field), int'(fld));
    endtask

    initial begin
        int  t;
        int  s;
        ev_t e;

        // Reset values
        step(3);
        chk("rst_setting", int'(o_setting), 0);
        chk("rst_field", int'(o_field), 0);
        chk("rst_inc", int'(o_inc), 0);
        chk("rst_dec", int'(o_dec), 0);
        chk("rst_blink", int'(o_blink), 1);
        reset = 1'b1;
        step(2);

        // Field walk, 10 cycles apart, with blink phase in SET_HOUR
        set_pulse(2'b01);
        step(4);
        chk("blink_on_phase", int'(o_blink), 1);
        step(1);
        chk("blink_off_phase", int'(o_blink), 0);
        step(4);
        set_pulse(2'b10);
        step(9);
        set_pulse(2'b11);
        step(9);
        set_pulse(2'b00);
        chk("setting_after_wrap", int'(o_setting), 0);

        // Hold-to-repeat in SET_MIN
        step(2);
        set_pulse(2'b01);
        step(2);
        set_pulse(2'b10);
        step(2);
        t = cyc + 1;
        push(t, K_INC, 2'b00);
`ifdef SET_AUTO_REPEAT_EN
        for (int k = 0; k <= 5; k++) push(t + int'(HOLD) + k * int'(REP), K_INC, 2'b00);
`endif
        i_up = 1'b1;
        step(20);
        chk("blink_forced_hold", int'(o_blink), 1);
        chk("setting_hold", int'(o_setting), 1);
        step(10);
        i_up = 1'b0;
        step(3);

        // Plain timeout in SET_SEC
        set_pulse(2'b11);
        s = cyc;
        step(TMO);
        chk("setting_before_timeout", int'(o_setting), 1);
        push(s + int'(TMO) + 1, K_FIELD, 2'b00);
        step(1);
        chk("setting_after_timeout", int'(o_setting), 0);

        // Button activity at idle cycle 49 restarts the timeout
        step(2);
        set_pulse(2'b01);
        s = cyc;
        step(48);
        push(s + 49, K_INC, 2'b00);
        i_up = 1'b1;
        step(1);
        i_up = 1'b0;
        step(2);
        chk("setting_timeout_restarted", int'(o_setting), 1);
        step(48);
        chk("setting_before_timeout2", int'(o_setting), 1);
        push(s + 100, K_FIELD, 2'b00);
        step(1);
        chk("setting_after_timeout2", int'(o_setting), 0);

        // Single down press, then both buttons held in SET_HOUR
        step(2);
        set_pulse(2'b01);
        step(2);
        push(cyc + 1, K_DEC, 2'b00);
        i_down = 1'b1;
        step(3);
        i_down = 1'b0;
        step(2);
        i_up   = 1'b1;
        i_down = 1'b1;
        step(20);
        chk("blink_forced_both", int'(o_blink), 1);
        push(cyc + 1, K_INC, 2'b00);
        i_down = 1'b0;
        step(3);
        i_up = 1'b0;
        step(2);

        // i_set coincident with an up edge: field advances, pulse suppressed, hold restarts
        step(2);
        t = cyc + 1;
        push(t, K_FIELD, 2'b10);
        i_set = 1'b1;
        i_up  = 1'b1;
        step(1);
        i_set = 1'b0;
        chk("field_set_with_edge", int'(o_field), 2);
`ifdef SET_AUTO_REPEAT_EN
        push(t + int'(HOLD), K_INC, 2'b00);
`endif
        step(9);
        i_up = 1'b0;
        step(3);

        // Asynchronous reset mid-repeat in SET_MIN
        t = cyc + 1;
        push(t, K_INC, 2'b00);
`ifdef SET_AUTO_REPEAT_EN
        push(t + int'(HOLD), K_INC, 2'b00);
`endif
        i_up = 1'b1;
        step(11);
        push(-1, K_FIELD, 2'b00);
        #2 reset = 1'b0;
        #1;
        chk("arst_setting", int'(o_setting), 0);
        chk("arst_field", int'(o_field), 0);
        chk("arst_inc", int'(o_inc), 0);
        chk("arst_dec", int'(o_dec), 0);
        chk("arst_blink", int'(o_blink), 1);
        i_up = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);
        chk("setting_after_reset_release", int'(o_setting), 0);

        // Enable loss in SET_HOUR forces IDLE on the next edge
        set_pulse(2'b01);
        step(2);
        push(cyc + 1, K_FIELD, 2'b00);
        i_enable = 1'b0;
        step(1);
        chk("setting_enable_low", int'(o_setting), 0);
        chk("field_enable_low", int'(o_field), 0);
        i_enable = 1'b1;
        step(5);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event: kind %0d field %0d never seen, required at cycle %0d", e.kind, e.fld, e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
